// File: rtl/uart_debug_tx_if.sv
// uart_debug_tx_if: write-side bus of the debug UART transmitter.
// The master pushes bytes and pulses clr_ovf. The slave (the transmitter)
// reports the FIFO status flags and the FIFO occupancy.
interface uart_debug_tx_if #(
   parameter int CNT_W = 5
);
   logic             wr_en;
   logic [7:0]       wr_data;
   logic             clr_ovf;
   logic             full;
   logic             empty;
   logic             overflow;
   logic [CNT_W-1:0] fifo_count;

   modport master (
      output wr_en, wr_data, clr_ovf,
      input  full, empty, overflow, fifo_count
   );

   modport slave (
      input  wr_en, wr_data, clr_ovf,
      output full, empty, overflow, fifo_count
   );
endinterface

// File: rtl/uart_debug_tx.sv
// uart_debug_tx: 8N1 UART transmitter for the board TxD pin, fed by a byte FIFO.
// Internal logic pushes debug bytes through the uart_debug_tx_if write bus.
// Each frame is 1 start bit, 8 data bits sent LSB first, and 1 stop bit,
// with CLK_DIV sysclk cycles per bit.
// Optional feature: define UART_TX_FLOW_CTRL_EN to gate new frames on cts_n.
// cts_n passes through a 2-flop synchronizer. The gate is checked only at a
// frame boundary, so a frame already on the line always completes.
// A pop is committed to the FIFO pointers one edge after the FSM takes the
// head byte. Because of this, fifo_count drops on the edge after START entry.
module uart_debug_tx #(
   parameter int CLK_DIV    = 427,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 5
) (
   input  logic             sysclk,
   input  logic             reset,
   uart_debug_tx_if.slave   bus,
   input  logic             cts_n,
   output logic             txd,
   output logic             busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int BIT_W = $clog2(CLK_DIV);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             full_flag;
   logic             empty_flag;
   logic             ovf_flag;
   logic             pop_pending;
   logic             push;
   logic             pop;
   logic             can_start;

   state_t           state;
   state_t           next_state;
   logic [BIT_W-1:0] bit_cnt;
   logic [BIT_W-1:0] next_bit_cnt;
   logic [2:0]       bit_idx;
   logic [2:0]       next_bit_idx;
   logic [7:0]       shift;
   logic [7:0]       next_shift;
   logic             next_txd;

   // A write is accepted against the registered full flag only.
   assign push = bus.wr_en & ~full_flag;

   assign bus.full       = full_flag;
   assign bus.empty      = empty_flag;
   assign bus.overflow   = ovf_flag;
   assign bus.fifo_count = count;

`ifdef UART_TX_FLOW_CTRL_EN
   logic cts_meta;
   logic cts_sync;

   // Two-flop synchronizer for the host clear-to-send. It resets to "not clear".
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         cts_meta <= 1'b1;
         cts_sync <= 1'b1;
      end else begin
         cts_meta <= cts_n;
         cts_sync <= cts_meta;
      end
   end

   assign can_start = ~cts_sync;
`else
   logic unused_cts;
   assign unused_cts = cts_n;
   assign can_start  = 1'b1;
`endif

   // FIFO storage. Contents are not reset; only the pointers matter.
   always_ff @(posedge sysclk) begin
      if (push) begin
         mem[wr_ptr] <= bus.wr_data;
      end else begin
         mem[wr_ptr] <= mem[wr_ptr];
      end
   end

   // Next occupancy. A push and a committed pop in the same cycle cancel out.
   always_comb begin
      count_next = count;
      case ({push, pop_pending})
         2'b10:   count_next = count + CNT_ONE;
         2'b01:   count_next = count - CNT_ONE;
         default: count_next = count;
      endcase
   end

   // FIFO pointers, occupancy and the registered full/empty flags.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= {PTR_W{1'b0}};
         rd_ptr      <= {PTR_W{1'b0}};
         count       <= {CNT_W{1'b0}};
         full_flag   <= 1'b0;
         empty_flag  <= 1'b1;
         pop_pending <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop_pending) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         count       <= count_next;
         full_flag   <= (count_next == CNT_FULL);
         empty_flag  <= (count_next == {CNT_W{1'b0}});
         pop_pending <= pop;
      end
   end

   // Sticky overflow. A dropped write takes priority over a clear in the same cycle.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         ovf_flag <= 1'b0;
      end else if (bus.wr_en && full_flag) begin
         ovf_flag <= 1'b1;
      end else if (bus.clr_ovf) begin
         ovf_flag <= 1'b0;
      end else begin
         ovf_flag <= ovf_flag;
      end
   end

   // Frame sequencer: next state, bit timing, and the line level for the next cycle.
   always_comb begin
      next_state   = state;
      next_bit_cnt = bit_cnt;
      next_bit_idx = bit_idx;
      next_shift   = shift;
      next_txd     = 1'b1;
      pop          = 1'b0;
      case (state)
         IDLE: begin
            next_bit_cnt = {BIT_W{1'b0}};
            next_bit_idx = 3'd0;
            if (!empty_flag && can_start) begin
               pop        = 1'b1;
               next_state = START;
               next_shift = mem[rd_ptr];
               next_txd   = 1'b0;
            end else begin
               next_txd = 1'b1;
            end
         end
         START: begin
            if (bit_cnt == BIT_LAST) begin
               next_state   = DATA;
               next_bit_cnt = {BIT_W{1'b0}};
               next_bit_idx = 3'd0;
               next_txd     = shift[0];
            end else begin
               next_bit_cnt = bit_cnt + BIT_ONE;
               next_txd     = 1'b0;
            end
         end
         DATA: begin
            if (bit_cnt == BIT_LAST) begin
               next_bit_cnt = {BIT_W{1'b0}};
               if (bit_idx == 3'd7) begin
                  next_state = STOP;
                  next_txd   = 1'b1;
               end else begin
                  next_bit_idx = bit_idx + 3'd1;
                  next_shift   = {1'b0, shift[7:1]};
                  next_txd     = shift[1];
               end
            end else begin
               next_bit_cnt = bit_cnt + BIT_ONE;
               next_txd     = shift[0];
            end
         end
         STOP: begin
            if (bit_cnt == BIT_LAST) begin
               next_bit_cnt = {BIT_W{1'b0}};
               next_bit_idx = 3'd0;
               if (!empty_flag && can_start) begin
                  pop        = 1'b1;
                  next_state = START;
                  next_shift = mem[rd_ptr];
                  next_txd   = 1'b0;
               end else begin
                  next_state = IDLE;
                  next_txd   = 1'b1;
               end
            end else begin
               next_bit_cnt = bit_cnt + BIT_ONE;
               next_txd     = 1'b1;
            end
         end
         default: begin
            next_state   = IDLE;
            next_bit_cnt = {BIT_W{1'b0}};
            next_bit_idx = 3'd0;
            next_txd     = 1'b1;
         end
      endcase
   end

   // Sequencer registers. txd and busy are registered. Reset returns the line high at once.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         bit_cnt <= {BIT_W{1'b0}};
         bit_idx <= 3'd0;
         shift   <= 8'h00;
         txd     <= 1'b1;
         busy    <= 1'b0;
      end else begin
         state   <= next_state;
         bit_cnt <= next_bit_cnt;
         bit_idx <= next_bit_idx;
         shift   <= next_shift;
         txd     <= next_txd;
         busy    <= (next_state != IDLE);
      end
   end

endmodule
